// File: rtl/spi_burst_engine.sv
// Burst sequencer between a register file and a byte-level SPI controller: TX/RX byte FIFOs plus framed slave-select.
// Optional feature macro: SPI_BURST_RX_OVERWRITE_EN (bursts run into a full RX FIFO, dropping bytes and setting rx_ovr).

module spi_burst_fifo #(
    parameter int AW = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  logic [7:0] wdata_i,
    input  logic       pop_i,
    output logic [7:0] rdata_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int DEPTH = 1 << AW;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic          full_q;
    logic          empty_q;
    logic          do_push;
    logic          do_pop;

    // On a full FIFO a simultaneous push/pop performs only the pop.
    assign do_pop  = pop_i && !empty_q;
    assign do_push = push_i && !full_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                empty_q <= 1'b0;
                full_q  <= ((wr_ptr_q + AW'(1)) == rd_ptr_q);
            end else if (do_pop && !do_push) begin
                full_q  <= 1'b0;
                empty_q <= ((rd_ptr_q + AW'(1)) == wr_ptr_q);
            end
        end
    end

    // First-word-fall-through head.
    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;
endmodule

module spi_burst_engine #(
    parameter int S   = 2,
    parameter int AW  = 4,
    parameter int GAP = 4,
    localparam int SW = (S > 1) ? $clog2(S) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tx_wr,
    input  logic [7:0]    tx_wdata,
    input  logic          rx_rd,
    output logic [7:0]    rx_rdata,
    input  logic          go,
    input  logic [SW-1:0] ss_sel,
    output logic          tx_full,
    output logic          tx_empty,
    output logic          rx_empty,
    output logic          rx_full,
    output logic          busy,
    output logic          rx_ovr,
    input  logic          ovr_clr,
    output logic          spi_start,
    output logic [7:0]    spi_din,
    input  logic [7:0]    spi_dout,
    input  logic          spi_done_tick,
    input  logic          spi_ready,
    output logic [S-1:0]  ss_n
);
    localparam logic [7:0] GAP_CNT = 8'(GAP);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ISSUE,
        ST_XFER,
        ST_HOLD
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [7:0]    cnt_q;
    logic [7:0]    cnt_d;
    logic [SW-1:0] sel_q;
    logic [SW-1:0] sel_d;
    logic          tx_pop;
    logic          rx_push;
    logic [7:0]    tx_head;
    logic          rx_room;

    spi_burst_fifo #(.AW(AW)) u_tx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (tx_wr),
        .wdata_i (tx_wdata),
        .pop_i   (tx_pop),
        .rdata_o (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty)
    );

    spi_burst_fifo #(.AW(AW)) u_rx_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (rx_push),
        .wdata_i (spi_dout),
        .pop_i   (rx_rd),
        .rdata_o (rx_rdata),
        .full_o  (rx_full),
        .empty_o (rx_empty)
    );

`ifdef SPI_BURST_RX_OVERWRITE_EN
    logic rx_ovr_q;

    assign rx_room = 1'b1;

    // A byte landing on a full RX FIFO is lost; a fresh overrun beats a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_ovr_q <= 1'b0;
        end else if (rx_push && rx_full) begin
            rx_ovr_q <= 1'b1;
        end else if (ovr_clr) begin
            rx_ovr_q <= 1'b0;
        end
    end

    assign rx_ovr = rx_ovr_q;
`else
    logic unused_ovr_clr;

    // Never issue a byte whose reply would have nowhere to go.
    assign rx_room        = !rx_full;
    assign rx_ovr         = 1'b0;
    assign unused_ovr_clr = ovr_clr;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sel_d     = sel_q;
        spi_start = 1'b0;
        tx_pop    = 1'b0;
        rx_push   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (go && !tx_empty) begin
                    state_d = ST_SETUP;
                    sel_d   = ss_sel;
                    cnt_d   = GAP_CNT;
                end
            end
            ST_SETUP: begin
                if (cnt_q <= 8'd1) begin
                    state_d = ST_ISSUE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_ISSUE: begin
                if (spi_ready && rx_room) begin
                    spi_start = 1'b1;
                    tx_pop    = 1'b1;
                    state_d   = ST_XFER;
                end
            end
            ST_XFER: begin
                if (spi_done_tick) begin
                    rx_push = 1'b1;
                    if (!tx_empty) begin
                        state_d = ST_ISSUE;
                    end else begin
                        state_d = ST_HOLD;
                        cnt_d   = GAP_CNT;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q <= 8'd1) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy    = (state_q != ST_IDLE);
    assign spi_din = tx_head;

    // An out-of-range index selects nothing; the burst still runs.
    for (genvar gi = 0; gi < S; gi++) begin : g_ss
        assign ss_n[gi] = !(busy && (32'(sel_q) == gi));
    end
endmodule

// File: doc/spi_burst_engine.md
Name: spi_burst_engine

Overview:
- Multi-byte transfer sequencer between the bus-slot register file and the byte-level SPI controller (`start`/`din`/`dout`/`ready`/`spi_done_tick`).
- Buffers outgoing bytes in a TX FIFO and issues one controller `start` per byte.
- Captures each received byte into an RX FIFO.
- Frames the whole burst with an automatically asserted slave-select, so software no longer polls `ready` per byte.

Parameters:
- S, 2, number of slave-select lines.
- AW, 4, FIFO address width; each FIFO holds 2^AW = 16 bytes.
- GAP, 4, idle `clk` cycles for ss setup before the first byte and ss hold after the last byte (1..255).

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high.
- tx_wr  input  1  push tx_wdata into TX FIFO; ignored when tx_full.
- tx_wdata  input  8  byte to transmit.
- rx_rd  input  1  pop RX FIFO head; ignored when rx_empty.
- rx_rdata  output  8  RX FIFO head, valid when !rx_empty (first-word-fall-through).
- go  input  1  one-cycle pulse: start a burst.
- ss_sel  input  log2(S) (min 1)  slave index, sampled on accepted go.
- tx_full  output  1  TX FIFO full.
- tx_empty  output  1  TX FIFO empty.
- rx_empty  output  1  RX FIFO empty.
- rx_full  output  1  RX FIFO full.
- busy  output  1  high in any state other than IDLE.
- rx_ovr  output  1  sticky RX overrun flag; meaningful only with the optional feature.
- ovr_clr  input  1  clears rx_ovr.
- spi_start  output  1  one-cycle start pulse to controller.
- spi_din  output  8  byte to controller, valid when spi_start is high.
- spi_dout  input  8  received byte from controller.
- spi_done_tick  input  1  controller byte-complete pulse.
- spi_ready  input  1  controller idle.
- ss_n  output  S  active-low slave selects.

Behaviour:
- Reset (synchronous, wins over all inputs):
  - FSM to IDLE; both FIFO pointers to 0.
  - ss_n = all 1; spi_start = 0; busy = 0; rx_ovr = 0.
  - tx_empty = rx_empty = 1; tx_full = rx_full = 0.
  - Reset mid-burst discards all FIFO contents and drops spi_start within one cycle. The controller may finish its byte; its done tick is ignored in IDLE.
- FIFOs: circular, AW-bit pointers plus a full/empty flag.
  - Push and pop in the same cycle on a non-empty, non-full FIFO leaves the count unchanged.
  - Push on full and pop on empty are silently ignored.
  - Simultaneous push and pop on a full FIFO: the pop happens and the push is ignored.
  - Pointers wrap at 2^AW - 1 -> 0.
- FSM states:
  - IDLE: go && !tx_empty -> SETUP; latch ss_sel, drive that ss_n bit low, load the GAP counter. go with tx_empty is ignored.
  - SETUP: count GAP cycles, then -> ISSUE.
  - ISSUE: requires spi_ready && !rx_full. Then pulse spi_start for exactly 1 cycle with spi_din = TX head, pop TX, -> XFER. Otherwise stay (stall).
  - XFER: on spi_done_tick, push spi_dout into RX. Then -> ISSUE if TX is non-empty, else -> HOLD with the GAP counter loaded.
  - HOLD: count GAP cycles, then ss_n = all 1, -> IDLE.
- Bytes pushed while busy are sent in the same burst if they arrive before the XFER->HOLD decision.
- go while busy is ignored.
- ss_sel >= S: ss_n stays all 1, but the burst still runs (data discarded by the bus). No error flag.
- Latency: go to first spi_start = GAP+1 cycles when the controller is ready.
- Byte count: one RX byte per TX byte; byte order preserved.

Optional Feature:
- Macro SPI_BURST_RX_OVERWRITE_EN.
- Defined:
  - ISSUE no longer stalls on rx_full.
  - A received byte that arrives while RX is full is dropped, and rx_ovr sets (sticky until ovr_clr or reset).
  - When ovr_clr and a new overrun occur in the same cycle, set wins.
- Not defined (default):
  - ISSUE stalls while rx_full; no byte is ever lost.
  - rx_ovr is tied to 0; ovr_clr is ignored.

Test Plan:
- Push 0xA5, 0x3C, 0x0F; go with ss_sel=1; controller model loops mosi->miso.
  - ss_n=2'b01 GAP cycles before the first spi_start.
  - Exactly 3 spi_start pulses with din A5, 3C, 0F.
  - RX pops A5, 3C, 0F.
  - ss_n=2'b11 GAP cycles after the last done tick; busy falls.
- Push 17 bytes into the idle TX FIFO -> tx_full after the 16th; the 17th is dropped; a burst sends exactly 16 bytes.
- No RX pops; 20-byte burst with TX refilled while busy.
  - Default: the engine stalls in ISSUE after 16 bytes; it resumes after 1 rx_rd; all 20 bytes are received in order.
  - With macro: no stall; rx_ovr=1 after the 17th byte; RX holds the first 16.
- go with tx_empty -> ss_n stays 2'b11, busy stays 0, no spi_start.
- Assert reset during XFER of byte 2 of 4 -> next cycle ss_n=2'b11, busy=0, tx_empty=rx_empty=1; the later done tick pushes nothing.
- Hold spi_ready low for 10 cycles in ISSUE -> no spi_start until ready rises; then one pulse on the next cycle.
